// File: rtl/regfile_pkg.sv
// Shared encodings for the register-pair unit: pair operations, register and pair
// indices, and the load sequencer state type.
package regfile_pkg;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_INC  = 3'b001;
   localparam logic [2:0] OP_DEC  = 3'b010;
   localparam logic [2:0] OP_SWAP = 3'b011;
   localparam logic [2:0] OP_ADDR = 3'b100;

   localparam logic [2:0] REG_B = 3'd0;
   localparam logic [2:0] REG_C = 3'd1;
   localparam logic [2:0] REG_D = 3'd2;
   localparam logic [2:0] REG_E = 3'd3;
   localparam logic [2:0] REG_H = 3'd4;
   localparam logic [2:0] REG_L = 3'd5;

   localparam logic [1:0] PAIR_BC = 2'd0;
   localparam logic [1:0] PAIR_DE = 2'd1;
   localparam logic [1:0] PAIR_HL = 2'd2;

   typedef enum logic [1:0] {
      LD_IDLE = 2'd0,
      LD_LO   = 2'd1,
      LD_HI   = 2'd2
   } ld_state_t;

endpackage

// File: rtl/pair_load_seq.sv
// Byte-serial pair loader: takes a low then a high operand byte and emits one
// byte-write strobe per accepted byte into the register file.
//
// state   | meaning
// --------+-------------------------------------------------
// LD_IDLE | no load in progress; ld_start latches pair_sel
// LD_LO   | waiting for the low byte (goes to reg[2p+1])
// LD_HI   | waiting for the high byte (goes to reg[2p])
module pair_load_seq #(
   parameter int DATA_W = 8,
   parameter int RA_W   = 3,
   parameter int PA_W   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_byte,
   input  logic [PA_W-1:0]   pair_sel,
   output logic              ld_ready,
   output logic              busy,
   output logic              seq_we,
   output logic [RA_W-1:0]   seq_idx,
   output logic [DATA_W-1:0] seq_data
);
   import regfile_pkg::*;

   ld_state_t       state;
   logic [PA_W-1:0] pair_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= LD_IDLE;
         pair_q   <= '0;
         ld_ready <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            LD_IDLE: if (ld_start) begin
               state    <= LD_LO;
               pair_q   <= pair_sel;
               ld_ready <= 1'b1;
               busy     <= 1'b1;
            end
            LD_LO: if (ld_valid) state <= LD_HI;
            LD_HI: if (ld_valid) begin
               state    <= LD_IDLE;
               ld_ready <= 1'b0;
               busy     <= 1'b0;
            end
            default: begin
               state    <= LD_IDLE;
               ld_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

   // Odd index (low byte) until the sequencer reaches the high-byte phase.
   assign seq_we   = ld_valid & ld_ready;
   assign seq_idx  = RA_W'({pair_q, (state != LD_HI)});
   assign seq_data = ld_byte;

endmodule

// File: rtl/regfile_pair_unit.sv
// General-purpose register file organised as 16-bit pairs, with a registered dual
// read port, in-place pair operations, an address driver and a byte-serial loader.
module regfile_pair_unit #(
   parameter int DATA_W    = 8,
   parameter int NUM_PAIRS = 3,
   parameter int RA_W      = 3,
   parameter int PA_W      = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [RA_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [RA_W-1:0]     rd_a_addr,
   input  logic [RA_W-1:0]     rd_b_addr,
   output logic [DATA_W-1:0]   rd_a_data,
   output logic [DATA_W-1:0]   rd_b_data,
   output logic                rd_err,
   input  logic [2:0]          pair_op,
   input  logic [PA_W-1:0]     pair_sel,
   input  logic [PA_W-1:0]     pair_sel_b,
   output logic [2*DATA_W-1:0] addr_out,
   output logic                addr_vld,
   input  logic                ld_start,
   input  logic                ld_valid,
   input  logic [DATA_W-1:0]   ld_byte,
   output logic                ld_ready,
   output logic                busy,
   output logic                collision
);
   import regfile_pkg::*;

   localparam int NUM_REGS = 2 * NUM_PAIRS;
   localparam int PW       = 2 * DATA_W;

   logic [DATA_W-1:0] regs     [NUM_REGS];
   logic [DATA_W-1:0] regs_nxt [NUM_REGS];
   logic [PW-1:0]     pw_val   [NUM_PAIRS];
   logic [NUM_PAIRS-1:0] pw_en;
   logic [NUM_REGS-1:0]  wr_own;
   logic [PW-1:0]     pv_a, pv_b;
   logic              op_ok, b_ok, swap_ok, addr_take, coll_nxt;
   logic [DATA_W-1:0] rd_a_nxt, rd_b_nxt;
   logic              rd_a_ok, rd_b_ok;
   logic              seq_we;
   logic [RA_W-1:0]   seq_idx;
   logic [DATA_W-1:0] seq_data;

   pair_load_seq #(.DATA_W(DATA_W), .RA_W(RA_W), .PA_W(PA_W)) u_load_seq (
      .clk      (clk),
      .reset    (reset),
      .ld_start (ld_start),
      .ld_valid (ld_valid),
      .ld_byte  (ld_byte),
      .pair_sel (pair_sel),
      .ld_ready (ld_ready),
      .busy     (busy),
      .seq_we   (seq_we),
      .seq_idx  (seq_idx),
      .seq_data (seq_data)
   );

   // An out-of-range pair_sel matches no pair, which turns every pair op into a NOP.
   always_comb begin
      pv_a  = '0;
      pv_b  = '0;
      op_ok = 1'b0;
      b_ok  = 1'b0;
      for (int p = 0; p < NUM_PAIRS; p++) begin
         if (pair_sel == PA_W'(p)) begin
            pv_a  = {regs[2*p], regs[2*p+1]};
            op_ok = !busy;
         end
         if (pair_sel_b == PA_W'(p)) begin
            pv_b = {regs[2*p], regs[2*p+1]};
            b_ok = 1'b1;
         end
      end
      swap_ok   = op_ok && b_ok && (pair_op == OP_SWAP) && (pair_sel != pair_sel_b);
      addr_take = op_ok && (pair_op == OP_ADDR);
   end

   always_comb begin
      for (int p = 0; p < NUM_PAIRS; p++) begin
         pw_en[p]  = 1'b0;
         pw_val[p] = '0;
         if (op_ok && pair_sel == PA_W'(p)) begin
            if (pair_op == OP_INC) begin
               pw_en[p]  = 1'b1;
               pw_val[p] = pv_a + PW'(1);
            end else if (pair_op == OP_DEC) begin
               pw_en[p]  = 1'b1;
               pw_val[p] = pv_a - PW'(1);
            end else if (swap_ok) begin
               pw_en[p]  = 1'b1;
               pw_val[p] = pv_b;
            end
         end
         if (swap_ok && pair_sel_b == PA_W'(p)) begin
            pw_en[p]  = 1'b1;
            pw_val[p] = pv_a;
         end
      end
   end

   // Priority per register: sequencer byte over pair op over the plain byte write.
   always_comb begin
      coll_nxt = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         wr_own[i]   = wr_en && (wr_addr == RA_W'(i));
         regs_nxt[i] = wr_own[i] ? wr_data : regs[i];
         if (pw_en[i/2]) begin
            if (wr_own[i]) coll_nxt = 1'b1;
            regs_nxt[i] = (i % 2 == 0) ? pw_val[i/2][PW-1:DATA_W] : pw_val[i/2][DATA_W-1:0];
         end
         if (seq_we && seq_idx == RA_W'(i)) begin
            if (wr_own[i]) coll_nxt = 1'b1;
            regs_nxt[i] = seq_data;
         end
      end
   end

   always_comb begin
      rd_a_nxt = '0;
      rd_b_nxt = '0;
      rd_a_ok  = 1'b0;
      rd_b_ok  = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_a_addr == RA_W'(i)) begin
            rd_a_nxt = regs[i];
            rd_a_ok  = 1'b1;
         end
         if (rd_b_addr == RA_W'(i)) begin
            rd_b_nxt = regs[i];
            rd_b_ok  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         rd_a_data <= '0;
         rd_b_data <= '0;
         rd_err    <= 1'b0;
         addr_out  <= '0;
         addr_vld  <= 1'b0;
         collision <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= regs_nxt[i];
         rd_a_data <= rd_a_nxt;
         rd_b_data <= rd_b_nxt;
         rd_err    <= !(rd_a_ok && rd_b_ok);
         addr_vld  <= addr_take;
         if (addr_take) addr_out <= pv_a;
         collision <= coll_nxt;
      end
   end

endmodule

// File: tb/tb_regfile_pair_unit.sv
// Directed and randomized bench for regfile_pair_unit against a byte-array model.
module tb_regfile_pair_unit;
   import regfile_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic [2:0] rd_a_addr, rd_b_addr;
   logic [7:0] rd_a_data, rd_b_data;
   logic       rd_err;
   logic [2:0] pair_op;
   logic [1:0] pair_sel, pair_sel_b;
   logic [15:0] addr_out;
   logic       addr_vld;
   logic       ld_start, ld_valid;
   logic [7:0] ld_byte;
   logic       ld_ready, busy, collision;

   int checks = 0;
   int errors = 0;

   logic [7:0]  m [6];
   logic [15:0] m_addr;
   int          rem;
   int          lpair;

   regfile_pair_unit dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr), .rd_a_data(rd_a_data),
      .rd_b_data(rd_b_data), .rd_err(rd_err), .pair_op(pair_op), .pair_sel(pair_sel),
      .pair_sel_b(pair_sel_b), .addr_out(addr_out), .addr_vld(addr_vld),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(ld_ready),
      .busy(busy), .collision(collision)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] pv(input int p);
      return {m[2*p], m[2*p+1]};
   endfunction

   // Predict one clock edge from the currently driven inputs, advance, then compare.
   task automatic cycle();
      logic [7:0]  nm [6];
      logic [7:0]  e_ra, e_rb;
      logic        e_err, e_vld, e_coll;
      logic [15:0] e_addr, va, vb;
      int nrem, wa, sa, sb, idx;
      bit wh;
      nm = m;
      e_ra   = (int'(rd_a_addr) < 6) ? m[rd_a_addr] : 8'h00;
      e_rb   = (int'(rd_b_addr) < 6) ? m[rd_b_addr] : 8'h00;
      e_err  = (int'(rd_a_addr) >= 6) || (int'(rd_b_addr) >= 6);
      e_vld  = 1'b0;
      e_coll = 1'b0;
      e_addr = m_addr;
      nrem   = rem;
      wa = int'(wr_addr);
      sa = int'(pair_sel);
      sb = int'(pair_sel_b);
      wh = wr_en && wa < 6;
      if (wh) nm[wa] = wr_data;
      if (rem == 0 && sa < 3) begin
         va = pv(sa);
         case (pair_op)
            OP_INC, OP_DEC: begin
               va = (pair_op == OP_INC) ? va + 16'd1 : va - 16'd1;
               nm[2*sa] = va[15:8];
               nm[2*sa+1] = va[7:0];
               if (wh && wa / 2 == sa) e_coll = 1'b1;
            end
            OP_SWAP: if (sb < 3 && sb != sa) begin
               vb = pv(sb);
               nm[2*sa] = vb[15:8];
               nm[2*sa+1] = vb[7:0];
               nm[2*sb] = va[15:8];
               nm[2*sb+1] = va[7:0];
               if (wh && (wa / 2 == sa || wa / 2 == sb)) e_coll = 1'b1;
            end
            OP_ADDR: begin
               e_vld  = 1'b1;
               e_addr = va;
            end
            default: ;
         endcase
      end
      if (rem > 0 && ld_valid) begin
         idx = (rem == 2) ? 2*lpair + 1 : 2*lpair;
         if (idx < 6) begin
            if (wh && wa == idx) e_coll = 1'b1;
            nm[idx] = ld_byte;
         end
         nrem = rem - 1;
      end
      if (rem == 0 && ld_start) begin
         nrem  = 2;
         lpair = int'(pair_sel);
      end
      if (reset) begin
         for (int i = 0; i < 6; i++) nm[i] = 8'h00;
         e_ra = 8'h00; e_rb = 8'h00; e_err = 1'b0; e_vld = 1'b0;
         e_coll = 1'b0; e_addr = 16'h0000; nrem = 0;
      end
      @(posedge clk);
      #1;
      m = nm;
      rem = nrem;
      m_addr = e_addr;
      chk("rd_a_data", rd_a_data, e_ra);
      chk("rd_b_data", rd_b_data, e_rb);
      chk("rd_err", rd_err, e_err);
      chk("addr_vld", addr_vld, e_vld);
      chk("addr_out", addr_out, e_addr);
      chk("collision", collision, e_coll);
      chk("busy", busy, nrem > 0);
      chk("ld_ready", ld_ready, nrem > 0);
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      cycle();
      wr_en = 1'b0;
   endtask

   task automatic op(input logic [2:0] o, input logic [1:0] s, input logic [1:0] sb);
      pair_op = o; pair_sel = s; pair_sel_b = sb;
      cycle();
      pair_op = OP_NOP;
   endtask

   task automatic rd(input logic [2:0] a, input logic [2:0] b);
      rd_a_addr = a; rd_b_addr = b;
      cycle();
   endtask

   initial begin
      for (int i = 0; i < 6; i++) m[i] = 8'h00;
      m_addr = 16'h0000; rem = 0; lpair = 0;
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_a_addr = '0; rd_b_addr = '0; pair_op = OP_NOP; pair_sel = '0; pair_sel_b = '0;
      ld_start = 1'b0; ld_valid = 1'b0; ld_byte = '0;
      cycle();
      cycle();
      reset = 1'b0;

      rd(REG_B, REG_C); rd(REG_D, REG_E); rd(REG_H, REG_L);
      chk("reset_l", rd_b_data, 8'h00);
      rd(3'b111, REG_B);
      chk("rd_err_111", rd_err, 1'b1);
      chk("rd_111_data", rd_a_data, 8'h00);
      rd(REG_B, REG_C);
      chk("rd_err_clear", rd_err, 1'b0);

      wr(REG_B, 8'h12); wr(REG_C, 8'h34);
      op(OP_ADDR, PAIR_BC, PAIR_BC);
      chk("addr_bc", addr_out, 16'h1234);
      chk("addr_vld_hi", addr_vld, 1'b1);
      cycle();
      chk("addr_vld_lo", addr_vld, 1'b0);

      wr(REG_H, 8'hFF); wr(REG_L, 8'hFF);
      op(OP_INC, PAIR_HL, PAIR_HL);
      rd(REG_H, REG_L);
      chk("inc_wrap", {rd_a_data, rd_b_data}, 16'h0000);
      op(OP_DEC, PAIR_HL, PAIR_HL);
      rd(REG_H, REG_L);
      chk("dec_wrap", {rd_a_data, rd_b_data}, 16'hFFFF);
      wr(REG_D, 8'h00); wr(REG_E, 8'hFF);
      op(OP_INC, PAIR_DE, PAIR_DE);
      rd(REG_D, REG_E);
      chk("inc_carry", {rd_a_data, rd_b_data}, 16'h0100);

      wr(REG_D, 8'h11); wr(REG_E, 8'h11); wr(REG_H, 8'h22); wr(REG_L, 8'h22);
      op(OP_SWAP, PAIR_DE, PAIR_HL);
      rd(REG_D, REG_H);
      chk("swap_de", rd_a_data, 8'h22);
      chk("swap_hl", rd_b_data, 8'h11);
      op(OP_SWAP, PAIR_HL, PAIR_HL);
      rd(REG_H, REG_L);
      chk("swap_same", {rd_a_data, rd_b_data}, 16'h1111);

      ld_start = 1'b1; pair_sel = PAIR_BC;
      cycle();
      ld_start = 1'b0;
      chk("ld_busy", busy, 1'b1);
      ld_valid = 1'b1; ld_byte = 8'h78; cycle(); ld_valid = 1'b0;
      cycle(); cycle(); cycle();
      chk("ld_wait_busy", busy, 1'b1);
      ld_valid = 1'b1; ld_byte = 8'h56; cycle(); ld_valid = 1'b0;
      chk("ld_done_busy", busy, 1'b0);
      chk("ld_done_ready", ld_ready, 1'b0);
      rd(REG_B, REG_C);
      chk("ld_bc", {rd_a_data, rd_b_data}, 16'h5678);

      ld_start = 1'b1; pair_sel = PAIR_BC; cycle(); ld_start = 1'b0;
      ld_valid = 1'b1; ld_byte = 8'h9A; cycle(); ld_valid = 1'b0;
      reset = 1'b1; cycle(); reset = 1'b0;
      chk("abort_busy", busy, 1'b0);
      rd(REG_B, REG_C);
      chk("abort_bc", {rd_a_data, rd_b_data}, 16'h0000);

      ld_start = 1'b1; pair_sel = PAIR_BC; cycle(); ld_start = 1'b0;
      ld_valid = 1'b1; ld_byte = 8'h11; cycle();
      ld_byte = 8'h22; wr_en = 1'b1; wr_addr = REG_B; wr_data = 8'hAA;
      cycle();
      ld_valid = 1'b0; wr_en = 1'b0;
      chk("coll_pulse", collision, 1'b1);
      cycle();
      chk("coll_clear", collision, 1'b0);
      rd(REG_B, REG_C);
      chk("coll_keep", {rd_a_data, rd_b_data}, 16'h2211);

      ld_start = 1'b1; pair_sel = PAIR_BC; cycle(); ld_start = 1'b0;
      ld_valid = 1'b1; ld_byte = 8'h33; cycle();
      ld_byte = 8'h44; wr_en = 1'b1; wr_addr = REG_E; wr_data = 8'h5A;
      cycle();
      ld_valid = 1'b0; wr_en = 1'b0;
      chk("nocoll", collision, 1'b0);
      rd(REG_B, REG_E);
      chk("nocoll_b", rd_a_data, 8'h44);
      chk("nocoll_e", rd_b_data, 8'h5A);

      for (int n = 0; n < 600; n++) begin
         reset      = ($urandom_range(0, 99) == 0);
         wr_en      = $urandom_range(0, 1) == 1;
         wr_addr    = 3'($urandom_range(0, 7));
         wr_data    = 8'($urandom);
         rd_a_addr  = 3'($urandom_range(0, 7));
         rd_b_addr  = 3'($urandom_range(0, 7));
         pair_op    = 3'($urandom_range(0, 7));
         pair_sel   = 2'($urandom_range(0, 3));
         pair_sel_b = 2'($urandom_range(0, 3));
         ld_start   = ($urandom_range(0, 5) == 0);
         ld_valid   = $urandom_range(0, 1) == 1;
         ld_byte    = 8'($urandom);
         cycle();
      end
      reset = 1'b0; wr_en = 1'b0; pair_op = OP_NOP; ld_start = 1'b0; ld_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_pair_unit.md
Name: regfile_pair_unit

Overview:
- Parametrised successor to the 8085 general-purpose register file: 2*NUM_PAIRS byte registers, organised as NUM_PAIRS 16-bit pairs (default BC, DE, HL).
- Adds a registered dual-read port, in-place 16-bit pair operations (INX, DCX, XCHG-style swap) and a byte-serial pair-load sequencer for LXI operands.
- Drives a registered memory address from any selected pair.
- Sits between the control unit and the internal data/address buses. Uses explicit valid/enable outputs; no tri-states, with bus muxing done upstream.

Parameters:
- DATA_W, 8, byte register width; a pair is 2*DATA_W.
- NUM_PAIRS, 3, number of register pairs; registers are indexed 0..2*NUM_PAIRS-1.
- RA_W, 3, register address width; must satisfy 2^RA_W >= 2*NUM_PAIRS.
- PA_W, 2, pair select width; must satisfy 2^PA_W >= NUM_PAIRS.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- wr_en  in  1  byte write strobe
- wr_addr  in  RA_W  byte register to write
- wr_data  in  DATA_W  byte write data
- rd_a_addr  in  RA_W  read port A address
- rd_b_addr  in  RA_W  read port B address
- rd_a_data  out  DATA_W  registered read A data
- rd_b_data  out  DATA_W  registered read B data
- rd_err  out  1  registered; 1 when either read address was out of range
- pair_op  in  3  pair operation: 000 NOP, 001 INC, 010 DEC, 011 SWAP, 100 ADDR
- pair_sel  in  PA_W  primary pair
- pair_sel_b  in  PA_W  second pair for SWAP
- addr_out  out  2*DATA_W  registered pair value for the address bus
- addr_vld  out  1  addr_out is valid this cycle
- ld_start  in  1  begin a two-byte load into pair_sel
- ld_valid  in  1  operand byte present on ld_byte
- ld_byte  in  DATA_W  operand byte, low byte first
- ld_ready  out  1  sequencer accepts a byte this cycle
- busy  out  1  sequencer not IDLE
- collision  out  1  one-cycle pulse when a byte write was dropped

Behaviour:
- Layout: pair p = {reg[2p], reg[2p+1]}; the even-indexed register is the high byte (B, D, H).
- Reset: all registers, rd_a_data, rd_b_data and addr_out go to 0; rd_err, addr_vld, ld_ready, busy and collision go to 0; FSM goes to IDLE. Reset mid-load aborts the load and keeps no partial byte.
- Reads: one-cycle latency; data is sampled from the pre-write register state (no write-through).
  - An out-of-range address (>= 2*NUM_PAIRS, e.g. 110/111 reserved for M/A) returns 0 and sets rd_err for that cycle.
- Byte write: lands at the clock edge when wr_en=1. An out-of-range wr_addr is ignored.
- Pair ops are accepted only in IDLE; ignored otherwise. An out-of-range pair_sel is treated as NOP.
  - INC/DEC: pair <= pair ± 1, modulo 2^(2*DATA_W). FFFF+1 wraps to 0000 and 0000-1 to FFFF; no flags are affected.
  - SWAP: pairs pair_sel and pair_sel_b exchange values in one cycle. pair_sel == pair_sel_b gives no change.
  - ADDR: addr_out <= pair value, addr_vld=1 next cycle; addr_vld=0 in all other cycles.
- Load FSM: IDLE -> LO on ld_start (latches pair_sel) -> HI after the low byte -> IDLE after the high byte.
  - ld_ready=1 in LO and HI; a byte is accepted when ld_valid && ld_ready.
  - The low byte is written to reg[2p+1] on acceptance, and the high byte to reg[2p].
  - Any number of wait cycles is allowed between bytes.
  - ld_start while busy is ignored. ld_start together with a pair_op in IDLE: the pair_op executes and the FSM still enters LO.
- Write priority, same register, same cycle: sequencer byte > pair op > wr_en.
  - The losing wr_en is dropped and collision pulses for one cycle.
  - Writes to non-conflicting registers all complete in the same cycle.

Decomposition:
- Shared package regfile_pkg: pair_op encodings, register index constants (REG_B..REG_L) and the pair constants PAIR_BC, PAIR_DE, PAIR_HL.
- One natural sub-module, pair_load_seq: the IDLE/LO/HI FSM with its ld_valid/ld_ready handshake. It emits a byte-write strobe, index and data to the main file.

Test Plan:
- Reset, then read all six registers -> 00; read addr 111 -> rd_data 00, rd_err=1 one cycle later.
- Write B=12, C=34; pair_op ADDR on BC -> next cycle addr_out=1234, addr_vld=1, then addr_vld=0.
- HL=FFFF, INC -> HL=0000; DEC -> FFFF; DE=00FF, INC -> 0100 (carry crosses the byte boundary).
- DE=1111, HL=2222, SWAP(DE,HL) -> DE=2222, HL=1111 in one cycle; SWAP(HL,HL) -> unchanged.
- ld_start on BC, bytes 0x78, 3 idle cycles, 0x56 -> BC=5678, busy high for exactly the transaction, ld_ready=0 after return to IDLE.
  - Repeat with reset asserted after the low byte -> BC=0000, FSM in IDLE.
- During a load, the high-byte acceptance coincides with wr_en to that same register (0xAA) -> the sequencer value is kept, collision=1 for one cycle.
  - The same cycle with wr_en to E -> both writes complete, no collision.
